mem_port_arbiter: RTL

//  Shares one single-port synchronous word RAM between the instruction-fetch requester (IF) and the

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/mem_load_align.sv | 24 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory port: request op/size codes, response owner tags,
// and the lane helpers used by both the arbiter and the load aligner.
package mem_pkg;

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D_RD,
        OWN_D_WR,
        OWN_D_ERR
    } owner_e;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = 4'b0001;
            SIZE_H:  size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Size 11 has no defined width, so it is rejected like any misaligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = lane[0];
            SIZE_W:  misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [31:0] wdata, input logic [1:0] size);
        case (size)
            SIZE_B:  lane_replicate = {4{wdata[7:0]}};
            SIZE_H:  lane_replicate = {2{wdata[15:0]}};
            default: lane_replicate = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Pulls a byte/half/word out of a RAM word at the given byte lane and
// sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {lane_i, 3'b000};
        case (size_i)
            SIZE_B:  result_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
            SIZE_H:  result_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous RAM between instruction fetch and load/store,
// one access per cycle, with a response pulse one cycle after each grant.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_instr,
    output logic [31:0]       if_rsp_pc,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [1:0]        d_op,
    input  logic [1:0]        d_size,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              d_rsp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic             d_valid, if_grant, d_grant, d_mis, d_access;
    logic [CNT_W-1:0] starve_q, starve_d;
    owner_e           owner_q, owner_d;
    logic [31:0]      pc_q, pc_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             sext_q, sext_d;
    logic [31:0]      load_data;

    // Grants are forced low during reset so nothing reaches the RAM in that cycle.
    always_comb begin
        d_valid  = !reset && d_req_valid && (d_op != MEM_DISABLE);
        if_grant = !reset && if_req_valid && (!d_valid || starve_q == CNT_MAX);
        d_grant  = d_valid && !if_grant;
        d_mis    = misaligned(d_size, d_addr[1:0]);
        d_access = d_grant && !d_mis;
    end

    assign if_req_ready = if_grant;
    assign d_req_ready  = d_grant;

    always_comb begin
        ram_en    = if_grant || d_access;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = 32'h0;
        if (if_grant) begin
            ram_addr = if_addr[ADDR_W+1:2];
        end else if (d_access) begin
            ram_addr = d_addr[ADDR_W+1:2];
            if (d_op == MEM_WRITE) begin
                ram_we    = size_mask(d_size) << d_addr[1:0];
                ram_wdata = lane_replicate(d_wdata, d_size);
            end
        end
    end

    always_comb begin
        starve_d = '0;
        if (if_req_valid && !if_grant)
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;

        owner_d = OWN_NONE;
        pc_d    = pc_q;
        lane_d  = lane_q;
        size_d  = size_q;
        sext_d  = sext_q;
        if (if_grant) begin
            owner_d = OWN_IF;
            pc_d    = if_addr;
        end else if (d_grant) begin
            if (d_mis)                  owner_d = OWN_D_ERR;
            else if (d_op == MEM_WRITE) owner_d = OWN_D_WR;
            else                        owner_d = OWN_D_RD;
            lane_d = d_addr[1:0];
            size_d = d_size;
            sext_d = (d_op == MEM_READ_SEXT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
            pc_q     <= 32'h0;
            lane_q   <= 2'b00;
            size_q   <= SIZE_B;
            sext_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            pc_q     <= pc_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
        end
    end

    mem_load_align u_align (
        .word_i   (ram_rdata),
        .lane_i   (lane_q),
        .size_i   (size_q),
        .sext_i   (sext_q),
        .result_o (load_data)
    );

    // Gating with reset drops an in-flight response in the reset cycle itself.
    always_comb begin
        if_rsp_valid = !reset && (owner_q == OWN_IF);
        if_rsp_instr = if_rsp_valid ? ram_rdata : 32'h0;
        if_rsp_pc    = if_rsp_valid ? pc_q : 32'h0;
        d_rsp_valid  = !reset && (owner_q == OWN_D_RD || owner_q == OWN_D_WR || owner_q == OWN_D_ERR);
        d_rsp_err    = !reset && (owner_q == OWN_D_ERR);
        d_rsp_rdata  = (!reset && owner_q == OWN_D_RD) ? load_data : 32'h0;
    end

endmodule
